// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared constants, state encoding and helpers for the load/store
//            unit (funct3 codes, FSM states, request legality check).
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int LSU_DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_MERGE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ERR     = 3'd4
    } lsu_state_t;

    // Misaligned or unsupported funct3 for the given direction.
    function automatic logic lsuReqIllegal(input logic isStore,
                                           input logic [2:0] funct3,
                                           input logic [1:0] byteOff);
        logic illegal;
        case (funct3)
            F3_B:    illegal = 1'b0;
            F3_H:    illegal = byteOff[0];
            F3_W:    illegal = (byteOff != 2'b00);
            F3_BU:   illegal = isStore;
            F3_HU:   illegal = isStore | byteOff[0];
            default: illegal = 1'b1;
        endcase
        return illegal;
    endfunction

    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Request/response handshake plus dataMemory port of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    // Core pipeline and dataMemory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_wdata, mem_we
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_data_align
// Purpose  : Combinational lane logic: load extract/extend and sub-word store
//            merge into the previously read memory word.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_data_align
    import lsu_pkg::*;
(
    input  wire logic [31:0] i_memWord,
    input  wire logic [31:0] i_storeData,
    input  wire logic [1:0]  i_byteOff,
    input  wire logic [2:0]  i_funct3,
    output logic      [31:0] o_loadData,
    output logic      [31:0] o_mergedWord
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_byteOff)
            2'd0:    w_byte = i_memWord[7:0];
            2'd1:    w_byte = i_memWord[15:8];
            2'd2:    w_byte = i_memWord[23:16];
            default: w_byte = i_memWord[31:24];
        endcase
        w_half = i_byteOff[1] ? i_memWord[31:16] : i_memWord[15:0];

        case (i_funct3)
            F3_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_loadData = {{16{w_half[15]}}, w_half};
            F3_W:    o_loadData = i_memWord;
            F3_BU:   o_loadData = {24'd0, w_byte};
            F3_HU:   o_loadData = {16'd0, w_half};
            default: o_loadData = 32'd0;
        endcase

        o_mergedWord = i_memWord;
        case (i_funct3)
            F3_B: begin
                case (i_byteOff)
                    2'd0:    o_mergedWord[7:0]   = i_storeData[7:0];
                    2'd1:    o_mergedWord[15:8]  = i_storeData[7:0];
                    2'd2:    o_mergedWord[23:16] = i_storeData[7:0];
                    default: o_mergedWord[31:24] = i_storeData[7:0];
                endcase
            end
            F3_H: begin
                if (i_byteOff[1]) o_mergedWord[31:16] = i_storeData[15:0];
                else              o_mergedWord[15:0]  = i_storeData[15:0];
            end
            default: o_mergedWord = i_storeData;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store to word-addressed dataMemory bridge with lane
//            extraction, read-modify-write sub-word stores and error reporting.
//            Optional macro LSU_PERF_CNT_EN adds saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = LSU_DATA_W
)
(
    input  wire logic         sysCLK,
    input  wire logic         resetN,
    load_store_unit_if.slave  bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);
    lsu_state_t         r_state;
    logic               r_reqReady;
    logic               r_isStore;
    logic [2:0]         r_funct3;
    logic [1:0]         r_byteOff;
    logic [DATA_W-1:0]  r_storeData;
    logic [ADDR_W-1:0]  r_memAddr;
    logic [DATA_W-1:0]  r_memWdata;
    logic               r_memWe;
    logic               r_respValid;
    logic               r_respErr;
    logic [DATA_W-1:0]  r_respRdata;

    logic [DATA_W-1:0]  w_loadData;
    logic [DATA_W-1:0]  w_mergedWord;
    logic               w_unusedAddrHi;

    // Byte address bits above the attached memory simply wrap.
    assign w_unusedAddrHi = ^bus.req_addr[31:ADDR_W+2];

    lsu_data_align u_align (
        .i_memWord    (bus.mem_rdata),
        .i_storeData  (r_storeData),
        .i_byteOff    (r_byteOff),
        .i_funct3     (r_funct3),
        .o_loadData   (w_loadData),
        .o_mergedWord (w_mergedWord)
    );

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_reqReady  <= 1'b1;
            r_isStore   <= 1'b0;
            r_funct3    <= 3'd0;
            r_byteOff   <= 2'd0;
            r_storeData <= '0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_memWe     <= 1'b0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respRdata <= '0;
        end else begin
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respRdata <= '0;
            r_memWe     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_reqReady  <= 1'b0;
                        r_isStore   <= bus.req_we;
                        r_funct3    <= bus.req_funct3;
                        r_byteOff   <= bus.req_addr[1:0];
                        r_storeData <= bus.req_wdata;
                        if (lsuReqIllegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                            r_state     <= ST_ERR;
                            r_respValid <= 1'b1;
                            r_respErr   <= 1'b1;
                        end else begin
                            r_state   <= ST_ACCESS;
                            r_memAddr <= bus.req_addr[ADDR_W+1:2];
                            if (bus.req_we && bus.req_funct3 == F3_W) begin
                                r_memWe    <= 1'b1;
                                r_memWdata <= bus.req_wdata;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_isStore && r_funct3 == F3_W) begin
                        r_state     <= ST_IDLE;
                        r_reqReady  <= 1'b1;
                        r_respValid <= 1'b1;
                    end else if (r_isStore) begin
                        // Read word arrives next cycle; write it back merged.
                        r_state <= ST_MERGE;
                        r_memWe <= 1'b1;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_MERGE: begin
                    r_memWdata  <= w_mergedWord;
                    r_state     <= ST_IDLE;
                    r_reqReady  <= 1'b1;
                    r_respValid <= 1'b1;
                end
                ST_CAPTURE: begin
                    r_respRdata <= w_loadData;
                    r_state     <= ST_IDLE;
                    r_reqReady  <= 1'b1;
                    r_respValid <= 1'b1;
                end
                ST_ERR: begin
                    r_state    <= ST_IDLE;
                    r_reqReady <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_reqReady <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_reqReady;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_err   = r_respErr;
    assign bus.resp_rdata = r_respRdata;
    assign bus.mem_addr   = r_memAddr;
    assign bus.mem_we     = r_memWe;
    // Merged word depends on the read data present only during MERGE.
    assign bus.mem_wdata  = (r_state == ST_MERGE) ? w_mergedWord : r_memWdata;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] r_perfLoads;
    logic [31:0] r_perfStores;
    logic [31:0] r_perfErrs;

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            r_perfLoads  <= 32'd0;
            r_perfStores <= 32'd0;
            r_perfErrs   <= 32'd0;
        end else if (r_respValid) begin
            if (r_respErr)      r_perfErrs   <= satInc(r_perfErrs);
            else if (r_isStore) r_perfStores <= satInc(r_perfStores);
            else                r_perfLoads  <= satInc(r_perfLoads);
        end
    end

    assign perf_loads  = r_perfLoads;
    assign perf_stores = r_perfStores;
    assign perf_errs   = r_perfErrs;
`endif

endmodule
`default_nettype wire
